wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/cpu_defs.sv | 42 ++++
 rtl/wb_stage_load_align.sv | 32 +++
 rtl/wb_stage.sv | 174 +++++++++++++++++
 tb/tb_wb_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: writeback FSM state encoding, access size codes and
// byte-lane helpers used by the memory/writeback stage.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } wbState_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 15;

    // Size code 11 falls through to the word case everywhere.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] sdat);
        case (size)
            SIZE_BYTE: return {4{sdat[7:0]}};
            SIZE_HALF: return {2{sdat[15:0]}};
            default:   return sdat;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the read word
// and sign- or zero-extends it to 32 bits.
module load_align
    import cpu_defs::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        case (addr)
            2'd0:    byteLane = rdata[7:0];
            2'd1:    byteLane = rdata[15:8];
            2'd2:    byteLane = rdata[23:16];
            default: byteLane = rdata[31:24];
        endcase
        halfLane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_BYTE: data = {{24{isSigned & byteLane[7]}}, byteLane};
            SIZE_HALF: data = {{16{isSigned & halfLane[15]}}, halfLane};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Memory access and register writeback stage: issues one bus access per load/store,
// waits for the ack (bounded by TIMEOUT) and drives the register file write port.
module wb_stage
    import cpu_defs::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        ex_valid,
    input  logic        ex_RegWrite,
    input  logic [4:0]  ex_regW,
    input  logic [31:0] ex_alu,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [31:0] ex_sdat,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [4:0]  regW,
    output logic [31:0] Wdat,
    output logic        RegWrite,
    output logic        align_err,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    wbState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic        memReqNext, memWeNext, regWriteNext, alignErrNext, busErrNext;
    logic [31:0] memAddrNext, memWdataNext, wdatNext;
    logic [3:0]  memBeNext;
    logic [4:0]  regWNext;

    // Attributes of the outstanding memory op, needed when the ack returns.
    logic [1:0] pOff, pOffNext, pSize, pSizeNext;
    logic       pSigned, pSignedNext, pLoad, pLoadNext;
    logic       pWrite, pWriteNext, pFlushed, pFlushedNext;

    logic        accept;
    logic [31:0] loadData;

    load_align u_load_align (
        .addr     (pOff),
        .size     (pSize),
        .isSigned (pSigned),
        .rdata    (mem_rdata),
        .data     (loadData)
    );

    assign stall  = (state == MEM);
    assign accept = ex_valid && !stall;

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memBeNext    = mem_be;
        memWdataNext = mem_wdata;
        regWNext     = regW;
        wdatNext     = Wdat;
        regWriteNext = 1'b0;
        alignErrNext = 1'b0;
        busErrNext   = 1'b0;
        pOffNext     = pOff;
        pSizeNext    = pSize;
        pSignedNext  = pSigned;
        pLoadNext    = pLoad;
        pWriteNext   = pWrite;
        pFlushedNext = pFlushed;

        case (state)
            IDLE, WB: begin
                stateNext = IDLE;
                if (accept) begin
                    regWNext = ex_regW;
                    if (!(ex_memRead || ex_memWrite)) begin
                        stateNext    = WB;
                        wdatNext     = ex_alu;
                        regWriteNext = ex_RegWrite && (ex_regW != 5'd0) && !flush;
                    end else if (isMisaligned(ex_size, ex_alu[1:0])) begin
                        alignErrNext = 1'b1;
                    end else begin
                        stateNext    = MEM;
                        cntNext      = CW'(TIMEOUT - 1);
                        memReqNext   = 1'b1;
                        memWeNext    = ex_memWrite;
                        memAddrNext  = {ex_alu[31:2], 2'b00};
                        memBeNext    = laneEnable(ex_size, ex_alu[1:0]);
                        memWdataNext = laneData(ex_size, ex_sdat);
                        pOffNext     = ex_alu[1:0];
                        pSizeNext    = ex_size;
                        pSignedNext  = ex_signed;
                        pLoadNext    = !ex_memWrite;
                        pWriteNext   = ex_RegWrite;
                        pFlushedNext = flush;
                    end
                end
            end
            MEM: begin
                if (flush) pFlushedNext = 1'b1;
                if (mem_ack) begin
                    stateNext    = WB;
                    memReqNext   = 1'b0;
                    memWeNext    = 1'b0;
                    if (pLoad) wdatNext = loadData;
                    regWriteNext = pLoad && pWrite && (regW != 5'd0) && !pFlushed && !flush;
                end else if (cnt == '0) begin
                    stateNext  = IDLE;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    busErrNext = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            regW      <= '0;
            Wdat      <= '0;
            RegWrite  <= 1'b0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            pOff      <= '0;
            pSize     <= '0;
            pSigned   <= 1'b0;
            pLoad     <= 1'b0;
            pWrite    <= 1'b0;
            pFlushed  <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_be    <= memBeNext;
            mem_wdata <= memWdataNext;
            regW      <= regWNext;
            Wdat      <= wdatNext;
            RegWrite  <= regWriteNext;
            align_err <= alignErrNext;
            bus_err   <= busErrNext;
            pOff      <= pOffNext;
            pSize     <= pSizeNext;
            pSigned   <= pSignedNext;
            pLoad     <= pLoadNext;
            pWrite    <= pWriteNext;
            pFlushed  <= pFlushedNext;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed and random instructions, a bus responder
// with scripted ack delays, and a monitor checking every register-file/error event.
module tb_wb_stage;

    localparam int TO   = cpu_defs::TIMEOUT_DEFAULT;
    localparam int K_WR = 0;
    localparam int K_AE = 1;
    localparam int K_BE = 2;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    logic ex_valid = 1'b0, ex_RegWrite = 1'b0, ex_memRead = 1'b0, ex_memWrite = 1'b0, ex_signed = 1'b0;
    logic [4:0]  ex_regW = '0;
    logic [31:0] ex_alu = '0, ex_sdat = '0;
    logic [1:0]  ex_size = '0;
    logic flushA = 1'b0, flushM = 1'b0;
    logic flush;
    logic mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic stall, RegWrite, align_err, bus_err;
    logic [4:0]  regW;
    logic [31:0] Wdat;

    assign flush = flushA | flushM;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .Rst(Rst), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_regW(ex_regW),
        .ex_alu(ex_alu), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_size(ex_size),
        .ex_signed(ex_signed), .ex_sdat(ex_sdat), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .regW(regW), .Wdat(Wdat), .RegWrite(RegWrite),
        .align_err(align_err), .bus_err(bus_err)
    );

    typedef struct {
        int          kind;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          delay;     // MEM cycle carrying the ack; 0 = never ack
        logic [31:0] rdata;
        bit          flushMem;
    } plan_t;

    exp_t  sbQ[$];
    plan_t planQ[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] rdata, input int off, input int n, input bit sg);
        logic [31:0] mask, val;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        val  = (rdata >> (8 * off)) & mask;
        if (sg && n < 4 && val[8 * n - 1]) val = val | ~mask;
        return val;
    endfunction

    // Bus responder: checks each request against the plan, holds it under watch, acks on schedule.
    bit    rBusy = 0;
    int    rCnt = 0;
    plan_t rCur;

    always @(negedge clk) begin
        if (Rst) begin
            rBusy   = 0;
            mem_ack = 1'b0;
            flushM  = 1'b0;
            planQ.delete();
        end else begin
            flushM = 1'b0;
            if (mem_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                rBusy     = 0;
                check("req_drop_after_ack", 32'(mem_req), 32'd0);
            end else if (rBusy) begin
                if (!mem_req) begin
                    rBusy = 0;
                    if (rCur.delay != 0) begin
                        checks++; errors++;
                        $display("FAIL req_dropped_early: got %0d cycles expected ack at %0d", rCnt, rCur.delay);
                    end else begin
                        check("timeout_len", 32'(rCnt), 32'(TO));
                        check("timeout_stall", 32'(stall), 32'd0);
                    end
                end else begin
                    rCnt++;
                    check("req_overrun", 32'(rCnt <= TO), 32'd1);
                    check("hold_addr", mem_addr, rCur.addr);
                    check("hold_be", 32'(mem_be), 32'(rCur.be));
                    check("hold_we", 32'(mem_we), 32'(rCur.we));
                    check("hold_wdata", mem_wdata, rCur.wdata);
                    check("mem_stall", 32'(stall), 32'd1);
                    if (rCnt == rCur.delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rCur.rdata;
                    end
                end
            end else if (mem_req) begin
                if (planQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h be %b expected no request", mem_addr, mem_be);
                end else begin
                    rCur  = planQ.pop_front();
                    rBusy = 1;
                    rCnt  = 1;
                    check("req_addr", mem_addr, rCur.addr);
                    check("req_be", 32'(mem_be), 32'(rCur.be));
                    check("req_we", 32'(mem_we), 32'(rCur.we));
                    check("req_wdata", mem_wdata, rCur.wdata);
                    check("req_stall", 32'(stall), 32'd1);
                    if (rCur.flushMem) flushM = 1'b1;
                    if (rCur.delay == 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rCur.rdata;
                    end
                end
            end
        end
    end

    // Monitor: every register write or error pulse must match the next expected event.
    exp_t monE;
    int   monK;

    always @(negedge clk) begin
        if (Rst) begin
            sbQ.delete();
        end else if (RegWrite || align_err || bus_err) begin
            monK = RegWrite ? K_WR : align_err ? K_AE : K_BE;
            check("single_event", 32'(RegWrite) + 32'(align_err) + 32'(bus_err), 32'd1);
            if (sbQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: got kind %0d regW %0d Wdat %h expected none", monK, regW, Wdat);
            end else begin
                monE = sbQ.pop_front();
                check("event_kind", 32'(monK), 32'(monE.kind));
                if (monE.kind == K_WR) begin
                    check("wr_regW", 32'(regW), 32'(monE.r));
                    check("wr_Wdat", Wdat, monE.d);
                end else begin
                    check("err_no_req", 32'(mem_req), 32'd0);
                    check("err_stall", 32'(stall), 32'd0);
                end
            end
        end
    end

    task automatic issue(input bit vRW, input logic [4:0] rw, input logic [31:0] alu, input bit rd,
                         input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] sdat,
                         input bit flushAcc, input int delay, input logic [31:0] rdata, input bit flushMem);
        int n, off, nb;
        plan_t p;
        exp_t e;
        nb = nBytes(sz);
        off = int'(alu[1:0]);
        ex_valid = 1'b1; ex_RegWrite = vRW; ex_regW = rw; ex_alu = alu; ex_memRead = rd;
        ex_memWrite = wr; ex_size = sz; ex_signed = sg; ex_sdat = sdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) begin
            checks++; errors++;
            $display("FAIL accept_timeout: stall still %b after %0d cycles expected 0", stall, n);
            ex_valid = 1'b0;
            return;
        end
        flushA = flushAcc;
        e.r = rw;
        e.d = 32'd0;
        if (!(rd || wr)) begin
            if (vRW && rw != 0 && !flushAcc) begin
                e.kind = K_WR; e.d = alu; sbQ.push_back(e);
            end
        end else if ((off % nb) != 0) begin
            e.kind = K_AE; sbQ.push_back(e);
        end else begin
            p.addr = alu & 32'hFFFF_FFFC;
            p.we = wr;
            p.delay = delay;
            p.rdata = rdata;
            p.flushMem = flushMem;
            for (int i = 0; i < 4; i++) begin
                p.be[i] = (i >= off && i < off + nb);
                p.wdata[8 * i +: 8] = sdat[8 * (i % nb) +: 8];
            end
            planQ.push_back(p);
            if (delay == 0) begin
                e.kind = K_BE; sbQ.push_back(e);
            end else if (!wr && vRW && rw != 0 && !flushAcc && !flushMem) begin
                e.kind = K_WR; e.d = refLoad(rdata, off, nb, sg); sbQ.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        flushA   = 1'b0;
        ex_alu   = $urandom;
        ex_sdat  = $urandom;
    endtask

    logic [31:0] rAddr;
    logic [1:0]  rSz;
    int          rKind, rDel;

    initial begin
        // Reset with garbage offered on the EX side
        ex_valid = 1'b1; ex_RegWrite = 1'b1; ex_regW = 5'd3; ex_alu = 32'h0000_0103; ex_memRead = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_regW", 32'(regW), 32'd0);
        check("rst_Wdat", Wdat, 32'd0);
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_errs", 32'(align_err) + 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        ex_valid = 1'b0; ex_memRead = 1'b0;
        @(posedge clk); #1;
        Rst = 1'b0;

        // Directed cases
        issue(1, 5'd5, 32'h0000_1234, 0, 0, 2'b10, 0, 32'd0, 0, 0, 32'd0, 0);            // ALU op
        issue(1, 5'd9, 32'h0000_0103, 1, 0, 2'b00, 1, 32'd0, 0, 3, 32'h80FF_FF7F, 0);    // signed byte load
        issue(1, 5'd4, 32'h0000_0102, 0, 1, 2'b01, 0, 32'h0000_ABCD, 0, 2, 32'd0, 0);    // half store
        issue(1, 5'd6, 32'h0000_0101, 1, 0, 2'b10, 0, 32'd0, 0, 1, 32'd0, 0);            // misaligned word
        issue(1, 5'd7, 32'h0000_0200, 1, 0, 2'b10, 0, 32'd0, 0, 0, 32'd0, 0);            // timeout
        issue(1, 5'd8, 32'h0000_0300, 1, 0, 2'b10, 0, 32'd0, 0, 2, 32'h1111_2222, 1);    // flush in MEM
        issue(1, 5'd0, 32'h0000_5555, 0, 0, 2'b10, 0, 32'd0, 0, 0, 32'd0, 0);            // regW=0
        issue(1, 5'd10, 32'h0000_0400, 1, 0, 2'b01, 0, 32'd0, 0, 15, 32'hF00D_8001, 0);  // ack on last cycle
        issue(1, 5'd11, 32'h0000_0404, 0, 0, 2'b10, 0, 32'd0, 1, 0, 32'd0, 0);           // flush at accept
        issue(1, 5'd12, 32'h0000_0500, 1, 1, 2'b11, 0, 32'hCAFE_BABE, 0, 1, 32'd0, 0);   // both high = store

        // Random traffic, mostly aligned, with back-to-back issue
        for (int i = 0; i < 150; i++) begin
            rKind = $urandom_range(0, 3);
            rSz   = 2'($urandom_range(0, 3));
            rAddr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (rSz == 2'b01) rAddr[0] = 1'b0;
                else if (rSz != 2'b00) rAddr[1:0] = 2'b00;
            end
            rDel = $urandom_range(0, 11);
            if (rDel == 11) rDel = TO;
            issue($urandom_range(0, 3) != 0, 5'($urandom), rAddr, rKind == 1 || rKind == 3, rKind >= 2,
                  rSz, 1'($urandom), $urandom, $urandom_range(0, 7) == 0, rDel, $urandom,
                  $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) != 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
        end

        repeat (TO + 5) @(negedge clk);
        check("sb_drained", 32'(sbQ.size()), 32'd0);
        check("plan_drained", 32'(planQ.size()), 32'd0);

        // Reset in the middle of a load: no write may follow
        @(posedge clk); #1;
        issue(1, 5'd7, 32'h0000_0600, 1, 0, 2'b10, 0, 32'd0, 0, 12, 32'h1234_5678, 0);
        repeat (3) begin @(posedge clk); #1; end
        Rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        Rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_RegWrite", 32'(RegWrite), 32'd0);
            check("post_rst_mem_req", 32'(mem_req), 32'd0);
            check("post_rst_stall", 32'(stall), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
